// File: rtl/add_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational adder among NUM_REQ
// requesters and registers each sum, tagged with its owner, into a one-deep slot.
module add_share_arbiter #(
    parameter int BIT_WIDTH = 14,
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_op0,
    input  logic [NUM_REQ*BIT_WIDTH-1:0]   req_op1,
    output logic [BIT_WIDTH-1:0]           add_element0,
    output logic [BIT_WIDTH-1:0]           add_element1,
    input  logic [BIT_WIDTH-1:0]           add_element,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [BIT_WIDTH-1:0]           rsp_data
);

    logic                slot_free;
    logic                any_req;
    logic                grant_en;
    logic                accept;
    logic [NUM_REQ-1:0]  hi_mask;
    logic [NUM_REQ-1:0]  hi_req;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] hi_idx;
    logic [ID_WIDTH-1:0] lo_idx;
    logic [ID_WIDTH-1:0] grant_idx;
    logic [ID_WIDTH-1:0] next_ptr;

    assign slot_free = !rsp_valid || rsp_ready;
    assign any_req   = |req_valid;
    assign grant_en  = slot_free && !rst && any_req;

    // Wrapping search: prefer the lowest valid index at or above rr_ptr,
    // otherwise fall back to the lowest valid index overall.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_mask[i] = (ID_WIDTH'(i) >= rr_ptr);
        end
    end

    assign hi_req = req_valid & hi_mask;

    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hi_req[i]) begin
                hi_idx = ID_WIDTH'(i);
            end
            if (req_valid[i]) begin
                lo_idx = ID_WIDTH'(i);
            end
        end
    end

    assign grant_idx = (|hi_req) ? hi_idx : lo_idx;

    always_comb begin
        req_ready    = '0;
        add_element0 = '0;
        add_element1 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_WIDTH'(i)) begin
                req_ready[i] = grant_en;
                if (any_req) begin
                    add_element0 = req_op0[i*BIT_WIDTH +: BIT_WIDTH];
                    add_element1 = req_op1[i*BIT_WIDTH +: BIT_WIDTH];
                end
            end
        end
    end

    assign accept   = |(req_valid & req_ready);
    assign next_ptr = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= add_element;
            rsp_id    <= grant_idx;
            rr_ptr    <= next_ptr;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter: the shared adder is modelled here as a
// plain truncating sum of the two operands the arbiter drives.
module tb_add_share_arbiter;

    localparam int BW = 14;
    localparam int NR = 4;
    localparam int IW = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*BW-1:0]   req_op0;
    logic [NR*BW-1:0]   req_op1;
    logic [BW-1:0]      add_element0;
    logic [BW-1:0]      add_element1;
    logic [BW-1:0]      add_element;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IW-1:0]      rsp_id;
    logic [BW-1:0]      rsp_data;

    int compared   = 0;
    int mismatched = 0;

    add_share_arbiter #(.BIT_WIDTH(BW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op0      (req_op0),
        .req_op1      (req_op1),
        .add_element0 (add_element0),
        .add_element1 (add_element1),
        .add_element  (add_element),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data)
    );

    assign add_element = add_element0 + add_element1;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
            $error("check %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [BW-1:0] a, input logic [BW-1:0] b);
        req_op0[idx*BW +: BW] = a;
        req_op1[idx*BW +: BW] = b;
    endtask

    logic [BW-1:0] exp_sum [NR];

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op0   = '0;
        req_op1   = '0;
        rsp_ready = 1'b1;

        // Reset: req_ready held low even with every request raised
        tick();
        req_valid = 4'hF;
        #1;
        chk("rst_ready_forced_low", 32'(req_ready), 32'h0);
        tick();
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_data", 32'(rsp_data), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);

        // Reset release with no requests
        req_valid = '0;
        rst       = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("idle_ready", 32'(req_ready), 32'h0);
            chk("idle_operand0", 32'(add_element0), 32'h0);
            tick();
            chk("idle_valid", 32'(rsp_valid), 32'h0);
            chk("idle_data", 32'(rsp_data), 32'h0);
            chk("idle_id", 32'(rsp_id), 32'h0);
        end

        // Single request from req0: 5 + 3
        set_ops(0, 14'h0005, 14'h0003);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 32'(req_ready), 32'h1);
        chk("single_operand0", 32'(add_element0), 32'h5);
        chk("single_operand1", 32'(add_element1), 32'h3);
        tick();
        req_valid = '0;
        chk("single_valid", 32'(rsp_valid), 32'h1);
        chk("single_id", 32'(rsp_id), 32'h0);
        chk("single_data", 32'(rsp_data), 32'h0008);
        tick();
        chk("drain_valid", 32'(rsp_valid), 32'h0);
        chk("drain_data_hold", 32'(rsp_data), 32'h0008);
        chk("drain_id_hold", 32'(rsp_id), 32'h0);

        // Wrap-around sum from req2 (rr_ptr is 1, search reaches 2)
        set_ops(2, 14'h3FFF, 14'h0002);
        req_valid = 4'b0100;
        #1;
        chk("wrap_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        chk("wrap_valid", 32'(rsp_valid), 32'h1);
        chk("wrap_id", 32'(rsp_id), 32'h2);
        chk("wrap_data", 32'(rsp_data), 32'h0001);
        tick();
        chk("wrap_drain", 32'(rsp_valid), 32'h0);

        // Reset so the fairness run starts from rr_ptr = 0
        rst = 1'b1;
        tick();
        rst = 1'b0;

        set_ops(0, 14'h0010, 14'h0001);
        set_ops(1, 14'h2000, 14'h2000);
        set_ops(2, 14'h3ABC, 14'h0543);
        set_ops(3, 14'h1111, 14'h3000);
        exp_sum[0] = 14'h0011;
        exp_sum[1] = 14'h0000;
        exp_sum[2] = 14'h3FFF;
        exp_sum[3] = 14'h0111;

        // Round-robin with every requester held valid: 0,1,2,3,0 back to back
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", 32'(req_ready), 32'(1) << (k % NR));
            tick();
            chk("rr_valid", 32'(rsp_valid), 32'h1);
            chk("rr_id", 32'(rsp_id), 32'(k % NR));
            chk("rr_data", 32'(rsp_data), 32'(exp_sum[k % NR]));
        end

        // Backpressure with req1 and req3 pending; slot holds req0's result
        req_valid = 4'b1010;
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'h0);
            tick();
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_id", 32'(rsp_id), 32'h0);
            chk("bp_data", 32'(rsp_data), 32'h0011);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'h2);
        tick();
        chk("bp_reload_valid", 32'(rsp_valid), 32'h1);
        chk("bp_reload_id", 32'(rsp_id), 32'h1);
        chk("bp_reload_data", 32'(rsp_data), 32'h0000);
        #1;
        chk("bp_next_ready", 32'(req_ready), 32'h8);
        tick();
        chk("bp_next_id", 32'(rsp_id), 32'h3);
        chk("bp_next_data", 32'(rsp_data), 32'h0111);

        // Reach rsp_valid=1, rr_ptr=2 via a req1 grant, then reset
        req_valid = 4'b0010;
        tick();
        chk("pre_rst_id", 32'(rsp_id), 32'h1);
        rst       = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_id", 32'(rsp_id), 32'h0);
        chk("mid_rst_data", 32'(rsp_data), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        tick();
        chk("post_rst_id", 32'(rsp_id), 32'h0);
        chk("post_rst_data", 32'(rsp_data), 32'h0011);
        req_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
- Round-robin arbiter that time-shares one combinational ADD instance (BIT_WIDTH-wide, truncating sum) among NUM_REQ requesters in the motion-estimation datapath.
- Each requester hands in an operand pair over a valid/ready handshake.
- The block drives the shared adder and registers the sum into a one-deep response slot. The slot carries the requester ID and has its own valid/ready handshake.
- Sits between the SAD/partial-sum producers and the single adder resource.

Parameters:
- BIT_WIDTH, 14, operand and result width; matches the ADD instance.
- NUM_REQ, 4, number of requesters (2..16).
- ID_WIDTH, 2, width of rsp_id; must satisfy NUM_REQ <= 2**ID_WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i = requester i has an operand pair.
- req_ready  output  NUM_REQ  one-hot (or zero) grant/accept, combinational.
- req_op0  input  NUM_REQ*BIT_WIDTH  packed first operands; requester i in bits [i*BIT_WIDTH +: BIT_WIDTH].
- req_op1  input  NUM_REQ*BIT_WIDTH  packed second operands, same packing.
- add_element0  output  BIT_WIDTH  operand 0 to the shared ADD.
- add_element1  output  BIT_WIDTH  operand 1 to the shared ADD.
- add_element  input  BIT_WIDTH  sum returned by the shared ADD.
- rsp_valid  output  1  response slot holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  ID_WIDTH  index of the requester that owns rsp_data.
- rsp_data  output  BIT_WIDTH  registered sum.

Behaviour:
- Reset (rst=1 at an edge): rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0.
  - req_ready is forced to 0 while rst=1.
  - Reset mid-operation drops any held response without handshake.
- slot_free = !rsp_valid || rsp_ready (combinational).
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr, ascending, wrapping modulo NUM_REQ. The first set bit is the winner g.
  - If slot_free && !rst && any req_valid, assert req_ready[g] only. Otherwise req_ready=0.
- Adder drive:
  - When a winner exists, add_element0/1 = req_op0/op1 of g.
  - With no valid request, drive the lowest-priority-irrelevant value 0 on both operands.
- Accept (req_valid[g] && req_ready[g] at an edge):
  - rsp_data <= add_element, rsp_id <= g, rsp_valid <= 1, rr_ptr <= (g+1) mod NUM_REQ.
- Drain without accept (rsp_valid && rsp_ready, no grant): rsp_valid <= 0. rsp_data and rsp_id hold their values.
- Simultaneous drain and accept: the slot is reloaded with the new result and rsp_valid stays 1. Full throughput is 1 result/cycle.
- Backpressure (rsp_valid=1, rsp_ready=0):
  - req_ready=0 and rr_ptr holds.
  - rsp_data and rsp_id are stable until accepted.
- No accept in a cycle: rr_ptr unchanged.
- Latency: accept at edge N gives rsp_valid=1 with the result after edge N, i.e. one cycle.
- Arithmetic: the sum is modulo 2**BIT_WIDTH. Carry-out is discarded, consistent with ADD.
- Requester rules: once req_valid is raised, the requester holds req_valid and its operands stable until req_ready. The block relies on this and does not check it.
- Fairness: a continuously asserting requester is granted within NUM_REQ accepts.

Test Plan:
- Reset release with no requests -> rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0 for all cycles.
- Single request: req0 op0=0x0005, op1=0x0003, rsp_ready=1 -> req_ready=4'b0001 same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=0x0008.
- Wrap-around: req2 op0=0x3FFF, op1=0x0002 -> rsp_id=2, rsp_data=0x0001.
- Round-robin fairness: all four requests held, rsp_ready=1 -> grants in order 0,1,2,3,0; one result per cycle with matching rsp_id/rsp_data.
- Backpressure: rsp_ready=0 for 3 cycles with req1 and req3 pending -> req_ready=0 and rsp_data/rsp_id stable throughout. After rsp_ready=1, the next grant follows rr_ptr and the slot reloads in the same cycle.
- Reset mid-operation: rsp_valid=1 and rr_ptr=2, assert rst for 1 cycle -> rsp_valid=0, rr_ptr=0. The first post-reset grant with all requests valid goes to req0.
